// File: rtl/rnic_req_queue.sv
// RNIC ingress request queue: in-order FIFO toward the memory controller with
// outstanding read/write tracking, read throttling and registered responses.
module rnic_req_queue #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 28,
   parameter int DEPTH      = 8,
   parameter int MAX_RD     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_type,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  mc_valid,
   output logic                  mc_type,
   output logic [DATA_WIDTH-1:0] mc_data,
   output logic [ADDR_WIDTH-1:0] mc_addr,
   input  logic                  mc_busy,
   input  logic                  mc_write_done,
   input  logic                  mc_read_done,
   input  logic [DATA_WIDTH-1:0] mc_rdata,
   output logic                  resp_rd_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_wr_valid,
   output logic [7:0]            rd_outstanding,
   output logic [7:0]            wr_outstanding,
   output logic                  err_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [7:0] RD_LIMIT = 8'(MAX_RD);

   logic                  type_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

   logic [AW:0]           wptr_q, wptr_d;
   logic [AW:0]           rptr_q, rptr_d;
   logic [7:0]            rd_cnt_q, rd_cnt_d;
   logic [7:0]            wr_cnt_q, wr_cnt_d;
   logic                  err_q, err_d;
   logic                  rd_vld_q, wr_vld_q;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [AW-1:0] widx, ridx;
   logic          empty, full, push, issue, head_rd, rd_inc, wr_inc;

   assign widx  = wptr_q[AW-1:0];
   assign ridx  = rptr_q[AW-1:0];
   assign empty = (wptr_q == rptr_q);
   assign full  = (widx == ridx) && (wptr_q[AW] != rptr_q[AW]);

   assign req_ready = !full;
   assign push      = req_valid && !full;

   assign mc_type = type_mem[ridx];
   assign mc_data = data_mem[ridx];
   assign mc_addr = addr_mem[ridx];
   assign head_rd = !mc_type;

   // Gate uses the registered count, so a same-cycle read_done cannot unblock.
   assign mc_valid = !empty && !(head_rd && (rd_cnt_q == RD_LIMIT));
   assign issue    = mc_valid && !mc_busy;
   assign rd_inc   = issue && head_rd;
   assign wr_inc   = issue && !head_rd;

   always_ff @(posedge clk) begin
      if (push) begin
         type_mem[widx] <= req_type;
         data_mem[widx] <= req_data;
         addr_mem[widx] <= req_addr;
      end
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push)  wptr_d = wptr_q + (AW+1)'(1);
      if (issue) rptr_d = rptr_q + (AW+1)'(1);
   end

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      unique case ({rd_inc, mc_read_done})
         2'b10:   rd_cnt_d = rd_cnt_q + 8'd1;
         2'b01:   if (rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 8'd1;
         default: rd_cnt_d = rd_cnt_q;
      endcase
      unique case ({wr_inc, mc_write_done})
         2'b10:   if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 8'd1;
         2'b01:   if (wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 8'd1;
         default: wr_cnt_d = wr_cnt_q;
      endcase
   end

   always_comb begin
      err_d = err_q
            | (mc_read_done  && (rd_cnt_q == '0))
            | (mc_write_done && (wr_cnt_q == '0));
      rdata_d = mc_read_done ? mc_rdata : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         err_q    <= 1'b0;
         rd_vld_q <= 1'b0;
         wr_vld_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         err_q    <= err_d;
         rd_vld_q <= mc_read_done;
         wr_vld_q <= mc_write_done;
         rdata_q  <= rdata_d;
      end
   end

   assign resp_rd_valid  = rd_vld_q;
   assign resp_wr_valid  = wr_vld_q;
   assign resp_rdata     = rdata_q;
   assign rd_outstanding = rd_cnt_q;
   assign wr_outstanding = wr_cnt_q;
   assign err_underflow  = err_q;

endmodule

// File: tb/tb_rnic_req_queue.sv
// Bench for rnic_req_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_rnic_req_queue;

   localparam int DW     = 16;
   localparam int AW     = 28;
   localparam int DEPTH  = 8;
   localparam int MAX_RD = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0, req_type = 1'b0;
   logic [DW-1:0] req_data = '0;
   logic [AW-1:0] req_addr = '0;
   logic          mc_busy = 1'b0, mc_write_done = 1'b0, mc_read_done = 1'b0;
   logic [DW-1:0] mc_rdata = '0;
   logic          req_ready, mc_valid, mc_type;
   logic [DW-1:0] mc_data, resp_rdata;
   logic [AW-1:0] mc_addr;
   logic          resp_rd_valid, resp_wr_valid, err_underflow;
   logic [7:0]    rd_outstanding, wr_outstanding;

   rnic_req_queue #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_RD(MAX_RD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
      .req_data(req_data), .req_addr(req_addr),
      .mc_valid(mc_valid), .mc_type(mc_type), .mc_data(mc_data), .mc_addr(mc_addr),
      .mc_busy(mc_busy), .mc_write_done(mc_write_done), .mc_read_done(mc_read_done),
      .mc_rdata(mc_rdata),
      .resp_rd_valid(resp_rd_valid), .resp_rdata(resp_rdata), .resp_wr_valid(resp_wr_valid),
      .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          t;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
   } req_t;

   req_t          q[$];
   int            m_rd, m_wr;
   logic          m_err, m_rdv, m_wrv;
   logic [DW-1:0] m_rdata;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_valid();
      return (q.size() > 0) && !(q[0].t == 1'b0 && m_rd == MAX_RD);
   endfunction

   task automatic check_all();
      check("req_ready", req_ready, q.size() < DEPTH);
      check("mc_valid", mc_valid, exp_valid());
      if (q.size() > 0) begin
         check("mc_type", mc_type, q[0].t);
         check("mc_data", mc_data, q[0].d);
         check("mc_addr", mc_addr, q[0].a);
      end
      check("rd_outstanding", rd_outstanding, m_rd);
      check("wr_outstanding", wr_outstanding, m_wr);
      check("resp_rd_valid", resp_rd_valid, m_rdv);
      check("resp_rdata", resp_rdata, m_rdata);
      check("resp_wr_valid", resp_wr_valid, m_wrv);
      check("err_underflow", err_underflow, m_err);
   endtask

   // Called at a falling edge; applies inputs across the next rising edge.
   task automatic step(input logic v, input logic t, input logic [DW-1:0] d,
                       input logic [AW-1:0] a, input logic busy, input logic wd,
                       input logic rdn, input logic [DW-1:0] rdat);
      bit   ev, er;
      int   rinc, winc;
      req_t h;
      ev = exp_valid();
      er = q.size() < DEPTH;
      req_valid = v; req_type = t; req_data = d; req_addr = a;
      mc_busy = busy; mc_write_done = wd; mc_read_done = rdn; mc_rdata = rdat;
      rinc = 0; winc = 0;
      if (ev && !busy) begin
         h = q.pop_front();
         if (h.t) winc = 1; else rinc = 1;
      end
      if (v && er) q.push_back('{t, d, a});
      if (rdn && m_rd == 0) m_err = 1'b1;
      if (wd  && m_wr == 0) m_err = 1'b1;
      m_rd = m_rd + rinc - int'(rdn);
      if (m_rd < 0) m_rd = 0;
      m_wr = m_wr + winc - int'(wd);
      if (m_wr < 0) m_wr = 0;
      if (m_wr > 255) m_wr = 255;
      m_rdv = rdn;
      m_wrv = wd;
      if (rdn) m_rdata = rdat;
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input logic busy);
      step(1'b0, 1'b0, '0, '0, busy, 1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      req_valid = 1'b0; mc_busy = 1'b0; mc_write_done = 1'b0; mc_read_done = 1'b0;
      #2 rst_n = 1'b0;
      q.delete();
      m_rd = 0; m_wr = 0; m_err = 1'b0; m_rdv = 1'b0; m_wrv = 1'b0; m_rdata = '0;
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      check_all();
   endtask

   initial begin
      do_reset();

      // Underflow: done pulses with nothing outstanding.
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
      check("underflow_set", err_underflow, 1'b1);
      repeat (3) idle(1'b0);
      check("underflow_held", err_underflow, 1'b1);
      check("underflow_wr_cnt", wr_outstanding, 8'd0);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 16'h1234);
      do_reset();
      check("underflow_cleared", err_underflow, 1'b0);

      // Fill and drain with the controller busy.
      for (int i = 0; i < 9; i++)
         step(1'b1, 1'b1, 16'(16'h100 + i), 28'(28'h0ABC000 + i), 1'b1, 1'b0, 1'b0, '0);
      check("full_ready_low", req_ready, 1'b0);
      check("full_valid", mc_valid, 1'b1);
      for (int i = 0; i < 8; i++) idle(1'b0);
      check("drain_wr_out", wr_outstanding, 8'd8);
      check("drain_empty", mc_valid, 1'b0);

      // Read throttle at MAX_RD.
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 16'(i), 28'(28'h0100 + i), 1'b1, 1'b0, 1'b0, '0);
      repeat (3) idle(1'b0);
      check("throttle_rd_out", rd_outstanding, 8'd2);
      check("throttle_blocked", mc_valid, 1'b0);
      check("throttle_head_rd", mc_type, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 16'hA5A5);
      check("release_resp_v", resp_rd_valid, 1'b1);
      check("release_rdata", resp_rdata, 16'hA5A5);
      check("release_valid", mc_valid, 1'b1);
      idle(1'b0);
      check("release_issued", rd_outstanding, 8'd2);

      // Bring counters down to rd=1, wr=1.
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 16'h0001);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
      check("pre_sim_rd", rd_outstanding, 8'd1);
      check("pre_sim_wr", wr_outstanding, 8'd1);

      // Simultaneous read issue with both completions.
      step(1'b1, 1'b0, 16'h7777, 28'h0777777, 1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 16'h5A5A);
      check("sim_rd_out", rd_outstanding, 8'd1);
      check("sim_wr_out", wr_outstanding, 8'd0);
      check("sim_both_resp", {resp_rd_valid, resp_wr_valid}, 2'b11);

      // Random mixed traffic across many pointer wraps.
      for (int i = 0; i < 400; i++) begin
         logic v, t, busy, wd, rdn;
         v    = 1'($urandom_range(0, 1));
         t    = 1'($urandom_range(0, 1));
         busy = ($urandom_range(0, 2) == 0);
         rdn  = (m_rd > 0) && ($urandom_range(0, 2) == 0);
         wd   = (m_wr > 0) && ($urandom_range(0, 2) == 0);
         step(v, t, 16'($urandom), 28'($urandom), busy, wd, rdn, 16'($urandom));
      end

      // Reset during traffic, then a stale completion.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 28'($urandom), 1'b0, 1'b0, 1'b0, '0);
      do_reset();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
      check("stale_done_err", err_underflow, 1'b1);
      check("stale_done_cnt", rd_outstanding, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rnic_req_queue.md
# rnic_req_queue

Ingress stage between the RNIC and the memory controller. It buffers RNIC read/write requests in a FIFO and presents them one at a time on the controller's `in_valid` / `out_busy` request port. It tracks outstanding reads and writes against the controller's `read_done` / `write_done` completions and returns registered responses to the RNIC. It throttles reads when the outstanding-read limit is reached.

## Interface

Parameters:
- `DATA_WIDTH`, 16, request/response data width.
- `ADDR_WIDTH`, 28, request address width.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `MAX_RD`, 16, maximum reads issued to the controller and not yet completed; 1..255.

Ports:
- `clk`, in, 1, single clock; all logic on the rising edge.
- `rst_n`, in, 1, reset, asynchronous and active-low.
- `req_valid`, in, 1, RNIC request present.
- `req_ready`, out, 1, queue can accept; equals `!full`.
- `req_type`, in, 1, 0 = read, 1 = write.
- `req_data`, in, `DATA_WIDTH`, write data; ignored for reads but stored.
- `req_addr`, in, `ADDR_WIDTH`, request address.
- `mc_valid`, out, 1, drives controller `in_valid`.
- `mc_type`, out, 1, drives controller `in_request_type`.
- `mc_data`, out, `DATA_WIDTH`, drives controller `in_request_data`.
- `mc_addr`, out, `ADDR_WIDTH`, drives controller `in_request_address`.
- `mc_busy`, in, 1, from controller `out_busy`.
- `mc_write_done`, in, 1, controller write completion pulse.
- `mc_read_done`, in, 1, controller read completion pulse.
- `mc_rdata`, in, `DATA_WIDTH`, controller `data_out`; valid with `mc_read_done`.
- `resp_rd_valid`, out, 1, read response pulse to RNIC.
- `resp_rdata`, out, `DATA_WIDTH`, read data; valid with `resp_rd_valid`.
- `resp_wr_valid`, out, 1, write acknowledge pulse to RNIC.
- `rd_outstanding`, out, 8, reads issued and not yet done.
- `wr_outstanding`, out, 8, writes issued and not yet done.
- `err_underflow`, out, 1, sticky; set when a done pulse arrives with its counter at 0.

## Operation

- **FIFO**
  - Storage is `DEPTH` entries of {type, data, addr}.
  - Read and write pointers are `log2(DEPTH)+1` bits; the MSB is the wrap bit.
  - Empty when the pointers are equal. Full when the index bits are equal and the wrap bits differ.
- **Push:** `req_valid && req_ready`. Entry is written at `wptr`; `wptr` increments.
  - No push while full; no bypass path.
- **Head presentation:** `mc_type`, `mc_data`, `mc_addr` are the entry at `rptr`, driven combinationally from storage.
- **Issue gate:** `mc_valid = !empty && !(head is read && rd_outstanding == MAX_RD)`.
  - A blocked read at the head also blocks the writes behind it; ordering is strictly in order.
- **Issue:** `mc_valid && !mc_busy`. `rptr` increments, and the matching outstanding counter increments.
- **Counters**
  - Read and write counters are independent and 8-bit.
  - Issue and done in the same cycle on the same counter leave it unchanged.
  - A done pulse at count 0 leaves the counter at 0 and sets `err_underflow`.
  - The write counter saturates at 255 and never wraps.
- **Responses**
  - `resp_rd_valid` is registered from `mc_read_done`; `resp_rdata` is registered from `mc_rdata` when `mc_read_done`, otherwise held.
  - `resp_wr_valid` is registered from `mc_write_done`.
  - Both pulses may be high in the same cycle.
- **Reset (asynchronous):**
  - Pointers, counters, `resp_rd_valid`, `resp_wr_valid`, `resp_rdata` and `err_underflow` clear to 0.
  - Therefore `mc_valid = 0` and `req_ready = 1` during and after reset.
  - Storage contents are don't-care.
  - Reset asserted mid-transfer drops all queued and outstanding state; completions that arrive afterwards for pre-reset requests set `err_underflow`.

## Timing

- **Enqueue-to-issue latency:** an entry pushed into an empty queue at edge N shows `mc_valid = 1` in the cycle after edge N. It may issue at edge N+1 if `mc_busy = 0`.
- **Throughput:** one push and one issue per cycle, simultaneously allowed.
  - When not full, a simultaneous push and pop leaves occupancy unchanged.
- **Full:** `req_ready` falls in the cycle after the `DEPTH`-th unpopped push. It rises in the cycle after the next issue.
- **Pointer wrap:** pointers wrap modulo `2·DEPTH`; occupancy stays correct across wrap.
- **Response latency:** done pulse at edge N → `resp_*` high for exactly the cycle after edge N.
- **Read throttle release:**
  - The `mc_read_done` edge that takes `rd_outstanding` from `MAX_RD` to `MAX_RD-1` makes a waiting head read valid in the following cycle.
  - A completion and an issue in that same cycle is not possible; the gate uses the registered count.

## Test plan

- **Reset defaults:** assert `rst_n = 0` mid-cycle → all outputs 0 except `req_ready = 1`, immediately and without a clock edge.
- **Fill and drain:** with `DEPTH = 8` and `mc_busy = 1`, push 9 writes.
  - Required: 8 accepted, `req_ready = 0` after the 8th.
  - Then `mc_busy = 0`: 8 issues on consecutive cycles in order, `wr_outstanding = 8`.
- **Wrap ordering:** stream 20 mixed requests with random `mc_busy` → issued sequence identical to the pushed sequence, including across the pointer wrap.
- **Read throttle:** `MAX_RD = 2`, queue 3 reads, no completions.
  - Required: 2 issue, then `mc_valid = 0` with a read at the head.
  - Pulse `mc_read_done` with `mc_rdata = 16'hA5A5` → `resp_rd_valid` with `resp_rdata = 16'hA5A5` in the next cycle; the third read issues in the cycle after that.
- **Simultaneous events:** issue a read while `mc_read_done = 1` and `mc_write_done = 1` at `rd_outstanding = 1`, `wr_outstanding = 1`.
  - Required: `rd_outstanding` stays 1, `wr_outstanding` becomes 0, and both response pulses fire in the same cycle.
- **Underflow:** pulse `mc_write_done` with `wr_outstanding = 0` → `err_underflow = 1` and held; counter stays 0; cleared only by reset.
